// File: rtl/rv32_wb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : rv32_wb_pkg
// Brief    : Shared encodings for the RV32 writeback stage.
// Revision : 1.0 - initial release
// ============================================================================
package rv32_wb_pkg;

   typedef enum logic [1:0] {
      WB_ALU  = 2'b00,
      WB_LOAD = 2'b01,
      WB_PC4  = 2'b10,
      WB_CSR  = 2'b11
   } wb_sel_e;

   typedef enum logic [1:0] {
      LS_BYTE     = 2'b00,
      LS_HALF     = 2'b01,
      LS_WORD     = 2'b10,
      LS_WORD_ALT = 2'b11
   } load_size_e;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'b00,
      ST_WAIT_MEM = 2'b01,
      ST_COMMIT   = 2'b10
   } wb_state_e;

   // Size 11 is treated as a word, so it shares the word alignment rule.
   function automatic logic load_misaligned(input logic [1:0] size, input logic [1:0] off);
      logic r;
      case (size)
         LS_BYTE: r = 1'b0;
         LS_HALF: r = off[0];
         default: r = (off != 2'b00);
      endcase
      return r;
   endfunction

endpackage
`default_nettype wire

// File: rtl/rv32_load_formatter.sv
`default_nettype none
// ============================================================================
// Module   : rv32_load_formatter
// Brief    : Combinational lane select and sign/zero extension of load data.
// Revision : 1.0 - initial release
// ============================================================================
module rv32_load_formatter
   import rv32_wb_pkg::*;
(
   input  logic [31:0] data_in,
   input  logic [1:0]  offset_in,
   input  logic [1:0]  size_in,
   input  logic        unsigned_in,
   output logic [31:0] data_out
);

   logic [31:0] w_shifted;
   logic [7:0]  w_byte;
   logic [15:0] w_half;

   assign w_shifted = data_in >> {offset_in, 3'b000};
   assign w_byte    = w_shifted[7:0];
   assign w_half    = offset_in[1] ? data_in[31:16] : data_in[15:0];

   always_comb begin
      data_out = data_in;
      case (size_in)
         LS_BYTE: data_out = {{24{~unsigned_in & w_byte[7]}}, w_byte};
         LS_HALF: data_out = {{16{~unsigned_in & w_half[15]}}, w_half};
         default: data_out = data_in;
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/rv32_wb_stage.sv
`default_nettype none
// ============================================================================
// Module   : rv32_wb_stage
// Brief    : RV32 writeback stage: result select, load wait and RF write.
// Revision : 1.0 - initial release
// ============================================================================
module rv32_wb_stage
   import rv32_wb_pkg::*;
(
   input  logic        clk_in,
   input  logic        reset_in,
   input  logic        valid_in,
   output logic        ready_out,
   input  logic        flush_in,
   input  logic [4:0]  rd_addr_in,
   input  logic        rf_wr_en_in,
   input  logic [1:0]  wb_sel_in,
   input  logic [31:0] alu_result_in,
   input  logic [31:0] pc_plus4_in,
   input  logic [31:0] csr_data_in,
   input  logic [1:0]  load_size_in,
   input  logic        load_unsigned_in,
   input  logic [31:0] dmem_data_in,
   input  logic        dmem_ack_in,
   output logic [4:0]  rd_addr_out,
   output logic        wr_en_out,
   output logic [31:0] rd_out,
   output logic        retire_out,
   output logic        misalign_out
);

   wb_state_e   r_state;
   logic [4:0]  r_rd_addr;
   logic        r_rf_wr_en;
   logic [1:0]  r_offset;
   logic [1:0]  r_load_size;
   logic        r_load_unsigned;

   logic        w_accept;
   logic        w_is_load;
   logic        w_misaligned;
   logic [31:0] w_result;
   logic [31:0] w_load_data;

   assign ready_out    = (r_state != ST_WAIT_MEM);
   assign w_accept     = valid_in & ready_out & ~flush_in;
   assign w_is_load    = (wb_sel_in == WB_LOAD);
   assign w_misaligned = w_is_load & load_misaligned(load_size_in, alu_result_in[1:0]);

   always_comb begin
      w_result = alu_result_in;
      case (wb_sel_in)
         WB_PC4:  w_result = pc_plus4_in;
         WB_CSR:  w_result = csr_data_in;
         default: w_result = alu_result_in;
      endcase
   end

   rv32_load_formatter u_fmt (
      .data_in     (dmem_data_in),
      .offset_in   (r_offset),
      .size_in     (r_load_size),
      .unsigned_in (r_load_unsigned),
      .data_out    (w_load_data)
   );

   always_ff @(posedge clk_in) begin
      if (reset_in) begin
         r_state         <= ST_IDLE;
         r_rd_addr       <= 5'd0;
         r_rf_wr_en      <= 1'b0;
         r_offset        <= 2'b00;
         r_load_size     <= 2'b00;
         r_load_unsigned <= 1'b0;
         rd_addr_out     <= 5'd0;
         rd_out          <= 32'd0;
         wr_en_out       <= 1'b0;
         retire_out      <= 1'b0;
         misalign_out    <= 1'b0;
      end else begin
         wr_en_out    <= 1'b0;
         retire_out   <= 1'b0;
         misalign_out <= 1'b0;
         case (r_state)
            ST_WAIT_MEM: begin
               // A flush outranks a same-cycle ack.
               if (flush_in) begin
                  r_state <= ST_IDLE;
               end else if (dmem_ack_in) begin
                  r_state     <= ST_COMMIT;
                  rd_addr_out <= r_rd_addr;
                  rd_out      <= w_load_data;
                  wr_en_out   <= r_rf_wr_en && (r_rd_addr != 5'd0);
                  retire_out  <= 1'b1;
               end
            end
            default: begin
               r_state <= ST_IDLE;
               if (w_accept) begin
                  r_rd_addr       <= rd_addr_in;
                  r_rf_wr_en      <= rf_wr_en_in;
                  r_offset        <= alu_result_in[1:0];
                  r_load_size     <= load_size_in;
                  r_load_unsigned <= load_unsigned_in;
                  if (w_misaligned) begin
                     misalign_out <= 1'b1;
                  end else if (w_is_load) begin
                     r_state <= ST_WAIT_MEM;
                  end else begin
                     r_state     <= ST_COMMIT;
                     rd_addr_out <= rd_addr_in;
                     rd_out      <= w_result;
                     wr_en_out   <= rf_wr_en_in && (rd_addr_in != 5'd0);
                     retire_out  <= 1'b1;
                  end
               end
            end
         endcase
      end
   end

endmodule
`default_nettype wire
